// File: rtl/cache_perf_counters.sv
// Five live event counters with sticky overflow flags, plus a set of published
// snapshot registers refreshed on demand or by an optional periodic sample timer.
module cache_perf_counters #(
    parameter int XLEN          = 32,
    parameter int SATURATE      = 1,
    parameter int SAMPLE_PERIOD = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            count_en,
    input  logic            clear,
    input  logic            snapshot,
    input  logic            ev_read,
    input  logic            ev_write,
    input  logic            ev_hit,
    input  logic            ev_miss,
    input  logic            ev_writeback,
    output logic [XLEN-1:0] hit_value,
    output logic [XLEN-1:0] miss_value,
    output logic [XLEN-1:0] read_value,
    output logic [XLEN-1:0] write_value,
    output logic [XLEN-1:0] writeback_value,
    output logic [4:0]      overflow,
    output logic            proto_err
);
    localparam int NUM_CTR = 5;

    logic [NUM_CTR-1:0]           ev;
    logic [NUM_CTR-1:0]           inc;
    logic                         take;
    logic                         auto_snap;
    logic [NUM_CTR-1:0][XLEN-1:0] pub;
    logic [NUM_CTR-1:0]           ovf;
    logic                         proto_q, proto_d;

    // Lane order matches the overflow bit order.
    assign ev   = {ev_writeback, ev_write, ev_read, ev_miss, ev_hit};
    assign inc  = ev & {NUM_CTR{count_en & ~clear}};
    assign take = snapshot | auto_snap;

    generate
        if (SAMPLE_PERIOD > 0) begin : g_timer
            localparam logic [15:0] TERM = 16'(SAMPLE_PERIOD - 1);
            logic [15:0] tmr_q, tmr_d;
            logic        tmr_hit;

            assign tmr_hit   = count_en & (tmr_q == TERM);
            // A clear in the terminal cycle suppresses the automatic snapshot.
            assign auto_snap = tmr_hit & ~clear;

            always_comb begin
                tmr_d = tmr_q;
                if (clear)         tmr_d = '0;
                else if (tmr_hit)  tmr_d = '0;
                else if (count_en) tmr_d = tmr_q + 16'd1;
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) tmr_q <= '0;
                else          tmr_q <= tmr_d;
            end
        end else begin : g_no_timer
            assign auto_snap = 1'b0;
        end
    endgenerate

    for (genvar g = 0; g < NUM_CTR; g++) begin : g_lane
        logic [XLEN-1:0] cnt_q, cnt_d;
        logic [XLEN-1:0] pub_q, pub_d;
        logic            ovf_q, ovf_d;

        always_comb begin
            cnt_d = cnt_q;
            ovf_d = ovf_q;
            // Published copy takes the value from before this cycle's increment.
            pub_d = take ? cnt_q : pub_q;
            if (clear) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (inc[g]) begin
                if (&cnt_q) begin
                    ovf_d = 1'b1;
                    cnt_d = (SATURATE != 0) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + XLEN'(1);
                end
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= '0;
                pub_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                pub_q <= pub_d;
                ovf_q <= ovf_d;
            end
        end

        assign pub[g] = pub_q;
        assign ovf[g] = ovf_q;
    end

    always_comb begin
        proto_d = proto_q;
        if (clear)
            proto_d = 1'b0;
        else if (count_en && ((ev_hit && ev_miss) || (ev_read && ev_write)))
            proto_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) proto_q <= 1'b0;
        else          proto_q <= proto_d;
    end

    assign hit_value       = pub[0];
    assign miss_value      = pub[1];
    assign read_value      = pub[2];
    assign write_value     = pub[3];
    assign writeback_value = pub[4];
    assign overflow        = ovf;
    assign proto_err       = proto_q;
endmodule

// File: tb/tb_cache_perf_counters.sv
// Four configurations share one stimulus stream; each is checked against a
// per-configuration reference model, plus directed table rows and corner sequences.
module tb_cache_perf_counters;
    localparam bit [4:0] H = 5'b00001, M = 5'b00010, R = 5'b00100, W = 5'b01000, B = 5'b10000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0, clr = 1'b0, snp = 1'b0;
    logic [4:0] ev = '0;

    logic [4:0][31:0] v0, v3;
    logic [4:0][7:0]  v1, v2;
    logic [3:0][4:0]  ovf;
    logic [3:0]       perr;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    cache_perf_counters #(.XLEN(32), .SATURATE(1), .SAMPLE_PERIOD(0)) u_main (
        .clk(clk), .reset_n(reset_n), .count_en(en), .clear(clr), .snapshot(snp),
        .ev_read(ev[2]), .ev_write(ev[3]), .ev_hit(ev[0]), .ev_miss(ev[1]), .ev_writeback(ev[4]),
        .hit_value(v0[0]), .miss_value(v0[1]), .read_value(v0[2]), .write_value(v0[3]),
        .writeback_value(v0[4]), .overflow(ovf[0]), .proto_err(perr[0]));
    cache_perf_counters #(.XLEN(8), .SATURATE(1), .SAMPLE_PERIOD(0)) u_sat8 (
        .clk(clk), .reset_n(reset_n), .count_en(en), .clear(clr), .snapshot(snp),
        .ev_read(ev[2]), .ev_write(ev[3]), .ev_hit(ev[0]), .ev_miss(ev[1]), .ev_writeback(ev[4]),
        .hit_value(v1[0]), .miss_value(v1[1]), .read_value(v1[2]), .write_value(v1[3]),
        .writeback_value(v1[4]), .overflow(ovf[1]), .proto_err(perr[1]));
    cache_perf_counters #(.XLEN(8), .SATURATE(0), .SAMPLE_PERIOD(0)) u_wrap8 (
        .clk(clk), .reset_n(reset_n), .count_en(en), .clear(clr), .snapshot(snp),
        .ev_read(ev[2]), .ev_write(ev[3]), .ev_hit(ev[0]), .ev_miss(ev[1]), .ev_writeback(ev[4]),
        .hit_value(v2[0]), .miss_value(v2[1]), .read_value(v2[2]), .write_value(v2[3]),
        .writeback_value(v2[4]), .overflow(ovf[2]), .proto_err(perr[2]));
    cache_perf_counters #(.XLEN(32), .SATURATE(1), .SAMPLE_PERIOD(4)) u_per4 (
        .clk(clk), .reset_n(reset_n), .count_en(en), .clear(clr), .snapshot(snp),
        .ev_read(ev[2]), .ev_write(ev[3]), .ev_hit(ev[0]), .ev_miss(ev[1]), .ev_writeback(ev[4]),
        .hit_value(v3[0]), .miss_value(v3[1]), .read_value(v3[2]), .write_value(v3[3]),
        .writeback_value(v3[4]), .overflow(ovf[3]), .proto_err(perr[3]));

    // Reference model: configuration d has width XL[d], saturation SAT[d], period PER[d].
    int     XL [4] = '{32, 8, 8, 32};
    bit     SAT[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int     PER[4] = '{0, 0, 0, 4};
    longint m_cnt[4][5];
    longint m_pub[4][5];
    bit     m_ovf[4][5];
    bit     m_pe [4];
    int     m_tmr[4];

    task automatic model_reset();
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 5; i++) begin
                m_cnt[d][i] = 0; m_pub[d][i] = 0; m_ovf[d][i] = 1'b0;
            end
            m_pe[d] = 1'b0; m_tmr[d] = 0;
        end
    endtask

    task automatic model_step(input bit e, input bit c, input bit s, input bit [4:0] evv);
        for (int d = 0; d < 4; d++) begin
            longint mx = (longint'(1) << XL[d]) - 1;
            bit tk = s || (PER[d] > 0 && e && !c && m_tmr[d] == PER[d] - 1);
            if (tk) for (int i = 0; i < 5; i++) m_pub[d][i] = m_cnt[d][i];
            if (c) begin
                for (int i = 0; i < 5; i++) begin m_cnt[d][i] = 0; m_ovf[d][i] = 1'b0; end
                m_pe[d] = 1'b0; m_tmr[d] = 0;
            end else if (e) begin
                for (int i = 0; i < 5; i++) if (evv[i]) begin
                    if (m_cnt[d][i] == mx) begin
                        m_ovf[d][i] = 1'b1;
                        m_cnt[d][i] = SAT[d] ? mx : 0;
                    end else m_cnt[d][i]++;
                end
                if ((evv[0] && evv[1]) || (evv[2] && evv[3])) m_pe[d] = 1'b1;
                if (PER[d] > 0) m_tmr[d] = (m_tmr[d] + 1) % PER[d];
            end
        end
    endtask

    function automatic longint actval(int d, int i);
        case (d)
            0:       return longint'(v0[i]);
            1:       return longint'(v1[i]);
            2:       return longint'(v2[i]);
            default: return longint'(v3[i]);
        endcase
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("cfg%0d_value%0d", d, i), actval(d, i), m_pub[d][i]);
                chk($sformatf("cfg%0d_ovf%0d", d, i), longint'(ovf[d][i]), longint'(m_ovf[d][i]));
            end
            chk($sformatf("cfg%0d_proto", d), longint'(perr[d]), longint'(m_pe[d]));
        end
    endtask

    // Called just after an active edge; drives one cycle and checks after the next edge.
    task automatic cyc(input bit e, input bit c, input bit s, input bit [4:0] evv);
        en = e; clr = c; snp = s; ev = evv;
        model_step(e, c, s, evv);
        @(posedge clk);
        #1;
        check_all();
    endtask

    typedef struct {
        bit       en, clr, snp;
        bit [4:0] ev;
        int       h, m, r, w, b;
        bit       pe;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(bit e, bit c, bit s, bit [4:0] evv,
                                int h, int m, int r, int w, int b, bit pe);
        vec_t v;
        v.en = e; v.clr = c; v.snp = s; v.ev = evv;
        v.h = h; v.m = m; v.r = r; v.w = w; v.b = b; v.pe = pe;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(1, 0, 0, R,     0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, R,     0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 0, R,     0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, H,     0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 0, H,     0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 0, 0, M,     0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 5'b0,  2, 1, 3, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, W,     2, 1, 3, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, W,     2, 1, 3, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, W,     2, 1, 3, 0, 0, 0);
        tbl[10] = mk(1, 0, 0, W,     2, 1, 3, 0, 0, 0);
        tbl[11] = mk(1, 0, 1, W,     2, 1, 3, 4, 0, 0);
        tbl[12] = mk(1, 0, 1, 5'b0,  2, 1, 3, 5, 0, 0);
        tbl[13] = mk(1, 0, 0, H | M, 2, 1, 3, 5, 0, 1);
        tbl[14] = mk(1, 1, 1, W | B, 3, 2, 3, 5, 0, 0);
        tbl[15] = mk(1, 0, 1, 5'b0,  0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 0, 0, R,     0, 0, 0, 0, 0, 0);
        tbl[17] = mk(0, 0, 1, R,     0, 0, 0, 0, 0, 0);
        tbl[18] = mk(1, 0, 0, R,     0, 0, 0, 0, 0, 0);
        tbl[19] = mk(0, 0, 1, 5'b0,  0, 0, 1, 0, 0, 0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset_n = 1'b1;

        for (int k = 0; k < 20; k++) begin
            cyc(tbl[k].en, tbl[k].clr, tbl[k].snp, tbl[k].ev);
            chk($sformatf("row%0d_hit", k),   longint'(v0[0]), tbl[k].h);
            chk($sformatf("row%0d_miss", k),  longint'(v0[1]), tbl[k].m);
            chk($sformatf("row%0d_read", k),  longint'(v0[2]), tbl[k].r);
            chk($sformatf("row%0d_write", k), longint'(v0[3]), tbl[k].w);
            chk($sformatf("row%0d_wb", k),    longint'(v0[4]), tbl[k].b);
            chk($sformatf("row%0d_proto", k), longint'(perr[0]), longint'(tbl[k].pe));
        end

        // 8-bit overflow: saturating holds at 255, wrapping returns to 0.
        cyc(1, 1, 0, 5'b0);
        repeat (256) cyc(1, 0, 0, H);
        cyc(1, 0, 1, 5'b0);
        chk("sat8_hit", longint'(v1[0]), 255);
        chk("sat8_ovf", longint'(ovf[1][0]), 1);
        chk("wrap8_hit", longint'(v2[0]), 0);
        chk("wrap8_ovf", longint'(ovf[2][0]), 1);
        chk("main_hit", longint'(v0[0]), 256);
        cyc(1, 1, 0, 5'b0);
        chk("sat8_ovf_clr", longint'(ovf[1]), 0);
        chk("wrap8_ovf_clr", longint'(ovf[2]), 0);

        // Asynchronous reset between edges with non-zero published values.
        cyc(1, 0, 0, R | H);
        cyc(1, 0, 1, B);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_main_read", longint'(v0[2]), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Periodic snapshot: 3, 7, 11 at every 4th enabled cycle.
        for (int k = 0; k < 12; k++) begin
            cyc(1, 0, 0, B);
            chk($sformatf("per_k%0d", k), longint'(v3[4]), (k < 3) ? 0 : 4 * ((k + 1) / 4) - 1);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 0, B);
            chk($sformatf("per_hold%0d", k), longint'(v3[4]), 11);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, B);
            chk($sformatf("per_resume%0d", k), longint'(v3[4]), (k < 3) ? 11 : 15);
        end

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bit e = ($urandom_range(0, 7) != 0);
            bit c = ($urandom_range(0, 39) == 0);
            bit s = ($urandom_range(0, 5) == 0);
            bit [4:0] evv = 5'($urandom());
            cyc(e, c, s, evv);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
